// File: rtl/riscv_pkg.sv
// Shared RV32I core types used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // One fetched instruction together with the PC it was read from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Fetch controller states: streaming, or halted on a misaligned target.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> pipeline bus: redirect input from execute and the {pc, instr}
// handshake toward decode.
//
// Handshake: a beat transfers on a rising edge where out_valid && out_ready.
// out_valid never depends on out_ready. While out_valid is high the payload
// stays stable until it is accepted or a redirect flushes it. A redirect is a
// single-cycle pulse sampled on the edge: redirect_valid has no ready and is
// always taken.
interface fetch_unit_if #(
  parameter int InstrWidth = 32
);
  import riscv_pkg::*;

  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [InstrWidth-1:0] out_instr;

  // Fetch side: produces instructions and consumes redirects.
  modport master (
    input  redirect_valid, redirect_pc, out_ready,
    output out_valid, out_pc, out_instr
  );

  // Pipeline side: consumes instructions and produces redirects.
  modport slave (
    output redirect_valid, redirect_pc, out_ready,
    input  out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry shifting FIFO of fetched instructions. Entry 0 is always the
// oldest (head). Flush wins over push and pop. Push into a full buffer is
// accepted only together with a pop.
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic         do_push;
  logic         do_pop;

  // Qualify requests: no pop from empty, no push into full without a pop.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged. The newcomer lands behind the survivor.
          if (count == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory, and queues {pc, instr} pairs for decode through a
// two-entry buffer. Redirects flush the buffer and retarget the PC. A
// misaligned target halts fetch until an aligned redirect arrives.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              AddrWidth  = 14,
  parameter int              InstrWidth = 32,
  parameter logic [XLEN-1:0] ResetPc    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [AddrWidth-1:0]  imem_addr,
  input  logic [InstrWidth-1:0] imem_instr,
  fetch_unit_if.master          bus,
  output logic                  fault,
  output fetch_state_e          dbg_state
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] pc;
  logic            push;
  logic            pop;
  logic            flush;
  logic            out_valid;
  logic [1:0]      count;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Push and pop decisions. A redirect suppresses both through the flush.
  always_comb begin
    flush     = bus.redirect_valid;
    pop       = out_valid && bus.out_ready;
    push      = (state == ST_RUN) && !flush && ((count != 2'd2) || pop);
    push_data = '{pc: pc, instr: imem_instr};
  end

  // PC and FSM: redirect first, otherwise advance on each accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= ResetPc;
      state <= ST_RUN;
    end else if (bus.redirect_valid) begin
      pc    <= bus.redirect_pc;
      state <= (bus.redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_FAULT;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  fetch_buffer u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_data),
    .head  (head),
    .count (count)
  );

  // Outputs come from buffer registers and are zeroed when the head is empty.
  always_comb begin
    out_valid     = (count != 2'd0) && (state == ST_RUN);
    bus.out_valid = out_valid;
    bus.out_pc    = out_valid ? head.pc : '0;
    bus.out_instr = out_valid ? head.instr : '0;
    imem_addr     = pc[AddrWidth-1:0];
    fault         = (state == ST_FAULT);
    dbg_state     = fetch_state_e'(state);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, flush, fault, PC alias
// and wrap, and asynchronous reset.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [13:0]  imem_addr;
  logic [31:0]  imem_instr;
  logic         fault;
  fetch_state_e dbg_state;
  int           n_checks;
  int           n_pass;

  fetch_unit_if #(.InstrWidth(32)) bus ();

  fetch_unit #(
    .AddrWidth  (14),
    .InstrWidth (32),
    .ResetPc    (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .bus        (bus),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: three real words at 0/4/8, a tagged pattern
  // elsewhere so every address returns a distinguishable word.
  function automatic logic [31:0] mem_word(input logic [13:0] a);
    case (a)
      14'h0000: mem_word = 32'h0000_0013;
      14'h0004: mem_word = 32'h0010_0093;
      14'h0008: mem_word = 32'h0020_0113;
      default:  mem_word = 32'hA500_0000 | {18'b0, a};
    endcase
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and release it 1 time unit after an edge.
  task automatic apply_reset(input logic ready);
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = ready;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One-cycle redirect pulse across a single edge.
  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", bus.out_pc);
    else n_pass++;
    n_checks++;
    if (bus.out_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", bus.out_instr);
    else n_pass++;
    n_checks++;
    if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 14'h0) $display("FAIL reset_addr: got %h want 0", imem_addr);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc[3];
    logic [31:0] exp_in[3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_in = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    apply_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] || bus.out_instr !== exp_in[i])
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[i], exp_in[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc[4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    apply_reset(1'b0);
    repeat (4) tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0)
      $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 14'h8) $display("FAIL stall_addr: got %h want 8", imem_addr);
    else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[i] ||
          bus.out_instr !== mem_word(exp_pc[i][13:0]))
        $display("FAIL drain_%0d: got v=%b pc=%h instr=%h want pc=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect_flush();
    apply_reset(1'b0);
    repeat (3) tick();
    bus.out_ready = 1'b1;
    redirect(32'h0000_0100);
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 14'h100) $display("FAIL flush_addr: got %h want 100", imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.out_instr !== 32'hA500_0100)
      $display("FAIL flush_first: got v=%b pc=%h instr=%h want v=1 pc=100 instr=a5000100",
               bus.out_valid, bus.out_pc, bus.out_instr);
    else n_pass++;
  endtask

  task automatic test_fault();
    redirect(32'h0000_0102);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (fault !== 1'b1 || bus.out_valid !== 1'b0 || imem_addr !== 14'h102 ||
          dbg_state !== FAULT)
        $display("FAIL fault_hold_%0d: got f=%b v=%b addr=%h want f=1 v=0 addr=102",
                 i, fault, bus.out_valid, imem_addr);
      else n_pass++;
      tick();
    end
    redirect(32'h0000_0200);
    n_checks++;
    if (fault !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL fault_clear: got f=%b v=%b want f=0 v=0", fault, bus.out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200)
      $display("FAIL fault_resume: got v=%b pc=%h want v=1 pc=200", bus.out_valid, bus.out_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    redirect(32'h0000_3FFC);
    tick();
    n_checks++;
    if (bus.out_pc !== 32'h3FFC || bus.out_instr !== 32'hA500_3FFC || imem_addr !== 14'h0)
      $display("FAIL alias_top: got pc=%h instr=%h addr=%h want pc=3ffc instr=a5003ffc addr=0",
               bus.out_pc, bus.out_instr, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_pc !== 32'h4000 || bus.out_instr !== 32'h0000_0013)
      $display("FAIL alias_wrap: got pc=%h instr=%h want pc=4000 instr=00000013",
               bus.out_pc, bus.out_instr);
    else n_pass++;
    redirect(32'hFFFF_FFFC);
    tick();
    n_checks++;
    if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_instr !== 32'hA500_3FFC)
      $display("FAIL wrap_top: got pc=%h instr=%h want pc=fffffffc instr=a5003ffc",
               bus.out_pc, bus.out_instr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0)
      $display("FAIL wrap_zero: got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset(1'b1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 ||
        fault !== 1'b0 || imem_addr !== 14'h0)
      $display("FAIL async_stream: got v=%b pc=%h instr=%h f=%b addr=%h want all 0",
               bus.out_valid, bus.out_pc, bus.out_instr, fault, imem_addr);
    else n_pass++;
    apply_reset(1'b1);
    redirect(32'h0000_0041);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fault !== 1'b0 || imem_addr !== 14'h0)
      $display("FAIL async_fault: got f=%b addr=%h want f=0 addr=0", fault, imem_addr);
    else n_pass++;
    apply_reset(1'b1);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0)
      $display("FAIL async_restart: got v=%b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_fault();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core. Sits directly upstream of the instruction memory: owns the program counter, drives the byte address into the combinational instruction memory, captures the returned 32-bit little-endian word together with its PC, and hands {pc, instr} pairs to decode through a valid/ready interface. A 2-entry output buffer decouples decode stalls from fetch. Redirects from execute (branches, jumps) flush the buffer and retarget the PC.

## Interface
- `AddrWidth`, 14: instruction memory byte-address width.
- `InstrWidth`, 32: instruction width.
- `ResetPc`, 32'h0000_0000: PC value loaded at reset.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  AddrWidth  byte address to instruction memory; always `pc[AddrWidth-1:0]`.
- `imem_instr`  in  InstrWidth  combinational read data for `imem_addr`.
- `redirect_valid`  in  1  execute requests PC change this cycle.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  buffer head holds a valid fetched instruction.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_pc`  out  32  PC of head entry; 0 when `out_valid`=0.
- `out_instr`  out  InstrWidth  head instruction; 0 when `out_valid`=0.
- `fault`  out  1  misaligned redirect target latched; fetch halted.

## Operation
- State machine: RUN, FAULT. Reset enters RUN.
- RUN, no redirect: if buffer has space (count<2, or count==2 with a pop this cycle), push {pc, imem_instr} and set pc <= pc+4 (32-bit, wraps at 2^32). Otherwise hold pc.
- Pop occurs when `out_valid && out_ready`.
- Redirect (either state), `redirect_pc[1:0]==0`: flush buffer (discard all entries, incl. any pop/push that cycle), pc <= redirect_pc, state <= RUN, fault <= 0. No push in the redirect cycle.
- Redirect with `redirect_pc[1:0]!=0`: flush buffer, pc <= redirect_pc, state <= FAULT, fault <= 1.
- FAULT: no pushes, pc held, `out_valid`=0. Leaves only on an aligned redirect or reset.
- Redirect beats pop and push in the same cycle.
- `imem_addr` truncates pc to AddrWidth bits; PCs at or above 2^AddrWidth alias into memory. `out_pc` carries the full 32-bit PC.
- Buffer is FIFO-ordered; head always oldest surviving entry.

## Timing
- Reset values: pc=ResetPc, state=RUN, buffer empty, `out_valid`=0, `out_pc`=0, `out_instr`=0, `fault`=0, `imem_addr`=ResetPc[AddrWidth-1:0].
- Fetch latency: instruction at pc appears at `out_*` the edge after it is addressed (1 cycle); first `out_valid` one edge after `rst_n` deasserts.
- Redirect-to-output latency: 2 edges (flush edge, then push edge).
- Sustained throughput with `out_ready`=1: one instruction per cycle.
- `out_*` are register outputs (buffer head), not combinational from `imem_instr`.
- `rst_n` assertion mid-operation clears all state immediately, independent of `clk`.

## Structure
- `riscv_pkg`: `XLEN`=32, `ILEN`=32, `fetch_entry_t` struct {pc, instr}, `fetch_state_e` enum {RUN, FAULT}.
- Sub-module `fetch_buffer`: 2-entry synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, head; flush priority over push/pop; push-when-full allowed only with simultaneous pop.
- `fetch_unit` holds pc register, FSM, push/redirect control.

## Test plan
- Reset then release, `out_ready`=1, memory words 0x00000013, 0x00100093, 0x00200113 at 0,4,8 -> `out_valid` rises 1 edge after release; `out_pc` sequence 0x0, 0x4, 0x8 with matching instrs on consecutive cycles.
- `out_ready`=0 for 4 cycles from start -> buffer fills to 2, pc stops at 0x8, `out_pc` holds 0x0; release `out_ready` -> 0x0, 0x4, 0x8 delivered, no drops or duplicates.
- Buffer full + `out_ready`=1 + `redirect_valid`=1 to 0x100 same cycle -> next cycle `out_valid`=0, `imem_addr`=0x100; following cycle `out_pc`=0x100.
- Redirect to 0x102 -> `fault`=1, `out_valid`=0 held 5+ cycles, pc stays 0x102; redirect to 0x200 -> `fault`=0, `out_pc`=0x200 two edges later.
- Redirect to 0x3FFC, stream -> `out_pc` 0x3FFC then 0x4000 with `imem_addr`=0x0000; redirect to 0xFFFFFFFC -> next `out_pc` 0x0.
- Assert `rst_n` asynchronously mid-stream between edges -> all outputs return to reset values before the next `clk` edge.
